elastic_rr_merge: RTL

Multi-channel successor to the single-channel elastic receive register. It buffers NUM_CH independent valid/ready input streams in per-channel FIFOs of DEPTH entries. A work-conserving round-robin arbiter merges them onto one valid/ready output that carries a channel tag. It adds almost-full flags, occupancy reporting and a synchronous flush, and sits between the channel producers and the shared downstream consumer.

---
 rtl/elastic_rr_merge_pkg.sv | 15 +
 rtl/elastic_rr_merge_if.sv | 32 +++
 rtl/elastic_rr_merge_fifo.sv | 72 +++++++
 rtl/elastic_rr_merge.sv | 121 ++++++++++++
 4 files changed

// File: rtl/elastic_rr_merge_pkg.sv
// Shared helpers for the elastic round-robin merge: width calculations used by
// the top level, the per-channel FIFO and the bus interface.
package elastic_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_rr_merge_if.sv
// Producer/consumer-side bundle of the elastic round-robin merge.
// The slave modport is the merge block itself.
interface elastic_rr_merge_if
  import elastic_pkg::*;
#(
  parameter int DW     = 16,
  parameter int DEPTH  = 4,
  parameter int NUM_CH = 4
);
  localparam int CW = clog2_min1(NUM_CH);
  localparam int OW = occ_width(DEPTH);

  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_vld;
  logic [NUM_CH-1:0]    in_rdy;
  logic [NUM_CH-1:0]    in_afull;
  logic [NUM_CH*OW-1:0] occ;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_vld;
  logic                 out_rdy;

  modport master (
    output in_data, in_vld, out_rdy,
    input  in_rdy, in_afull, occ, out_data, out_ch, out_vld
  );

  modport slave (
    input  in_data, in_vld, out_rdy,
    output in_rdy, in_afull, occ, out_data, out_ch, out_vld
  );
endinterface

// File: rtl/elastic_rr_merge_fifo.sv
// One channel's elastic buffer: circular storage with independent head/tail
// wrapping at DEPTH, occupancy count, almost-full flag and synchronous clear.
module elastic_fifo #(
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int OW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] i_data,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_empty,
  output logic [OW-1:0] o_occ,
  output logic          o_afull
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;
  logic          w_clr;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_clr   = rst | flush;
  assign w_full  = (r_occ == OW'(DEPTH));
  assign o_empty = (r_occ == '0);
  // No pass-through: a full channel stays not-ready even while being popped.
  assign o_rdy   = ~w_full & ~w_clr;
  assign w_push  = i_vld & o_rdy;
  assign w_pop   = i_pop & ~o_empty & ~w_clr;
  assign o_head  = r_mem[r_head];
  assign o_occ   = r_occ;
  assign o_afull = (r_occ >= OW'(AFULL_TH));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= wrap_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= wrap_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/elastic_rr_merge.sv
// Merges NUM_CH buffered valid/ready channels onto one tagged output with a
// work-conserving round-robin arbiter that locks its grant while stalled.
module elastic_rr_merge
  import elastic_pkg::*;
#(
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int NUM_CH   = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  elastic_rr_merge_if.slave  bus
);
  localparam int CW = clog2_min1(NUM_CH);
  localparam int OW = occ_width(DEPTH);

  // Arbiter state is sized by CW, so its struct is declared per instance.
  typedef struct packed {
    logic [CW-1:0] rr_ptr;
    logic          locked;
    logic [CW-1:0] lock_ch;
  } arb_state_t;

  arb_state_t        r_arb;
  logic [DW-1:0]     w_head [NUM_CH];
  logic [OW-1:0]     w_occ  [NUM_CH];
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_rdy;
  logic [NUM_CH-1:0] w_afull;
  logic [CW-1:0]     w_scan;
  logic [CW-1:0]     w_idx;
  logic              w_found;
  logic [CW-1:0]     w_sel;
  logic              w_vld;
  logic              w_hs;
  logic [CW-1:0]     w_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    elastic_fifo #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH),
      .OW       (OW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_data  (bus.in_data[c*DW +: DW]),
      .i_vld   (bus.in_vld[c]),
      .o_rdy   (w_rdy[c]),
      .i_pop   (w_pop[c]),
      .o_head  (w_head[c]),
      .o_empty (w_empty[c]),
      .o_occ   (w_occ[c]),
      .o_afull (w_afull[c])
    );
  end

  assign bus.in_rdy   = w_rdy;
  assign bus.in_afull = w_afull;

  always_comb begin
    bus.occ = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.occ[c*OW +: OW] = w_occ[c];
    end
  end

  // First non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    w_scan  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CW'((int'(r_arb.rr_ptr) + k) % NUM_CH);
      if (!w_found && !w_empty[w_idx]) begin
        w_scan  = w_idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_sel  = r_arb.locked ? r_arb.lock_ch : w_scan;
  assign w_vld  = (|(~w_empty)) & ~flush & ~rst;
  assign w_hs   = w_vld & bus.out_rdy;
  assign w_next = (w_sel == CW'(NUM_CH - 1)) ? '0 : w_sel + CW'(1);

  assign bus.out_vld  = w_vld;
  assign bus.out_ch   = w_vld ? w_sel : '0;
  assign bus.out_data = w_vld ? w_head[w_sel] : '0;

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_hs && (w_sel == CW'(c))) begin
        w_pop[c] = 1'b1;
      end else begin
        w_pop[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_arb <= '0;
    end else if (w_hs) begin
      r_arb.rr_ptr <= w_next;
      r_arb.locked <= 1'b0;
    end else if (w_vld) begin
      r_arb.locked  <= 1'b1;
      r_arb.lock_ch <= w_sel;
    end else begin
      r_arb <= r_arb;
    end
  end
endmodule
